// File: rtl/mat_mul_seq_ctrl.sv
// mat_mul_seq_ctrl: load/fetch/compute/drain sequencer for the 3x3 parallel matrix-multiply datapath.
// Define MAT_MUL_SEQ_CTRL_PERF_EN to add the perf_cycles busy-cycle counter output.
module mat_mul_seq_ctrl #(
    parameter int DWIDTH      = 16,
    parameter int AWIDTH      = 4,
    parameter int N_ELEM      = 9,
    parameter int COMPUTE_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DWIDTH-1:0]   s_data,
    output logic [AWIDTH-1:0]   ram_addr,
    output logic [DWIDTH-1:0]   ram_wdata,
    output logic                ram_we_a,
    output logic                ram_we_b,
    output logic                op_ld_en,
    output logic [AWIDTH-1:0]   op_ld_idx,
    output logic [AWIDTH-1:0]   res_sel,
    input  logic [2*DWIDTH-1:0] res_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*DWIDTH-1:0] m_data,
    output logic                done
`ifdef MAT_MUL_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);
    localparam logic [2:0] IDLE = 3'd0, LOAD_A = 3'd1, LOAD_B = 3'd2, FETCH = 3'd3,
                           WAIT = 3'd4, SEL = 3'd5, CAP = 3'd6, OUT = 3'd7;
    localparam logic [AWIDTH-1:0] LAST  = AWIDTH'(N_ELEM - 1);
    localparam logic [AWIDTH-1:0] WLAST = AWIDTH'(COMPUTE_LAT - 1);

    logic [2:0]        state;
    logic [AWIDTH-1:0] cnt;
    logic              rd_v;
    logic              hs;

    assign s_ready = (state == LOAD_A) || (state == LOAD_B);
    assign hs      = s_valid && s_ready;

    // rd_v marks a read address issued last cycle; its RAM data is valid one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_v      <= 1'b0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we_a  <= 1'b0;
            ram_we_b  <= 1'b0;
            op_ld_en  <= 1'b0;
            op_ld_idx <= '0;
            res_sel   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            done      <= 1'b0;
        end else begin
            ram_we_a <= 1'b0;
            ram_we_b <= 1'b0;
            rd_v     <= 1'b0;
            done     <= 1'b0;
            op_ld_en <= rd_v;
            if (rd_v) op_ld_idx <= ram_addr;
            case (state)
                IDLE: if (start) begin
                    state <= LOAD_A;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
                LOAD_A, LOAD_B: if (hs) begin
                    ram_addr  <= cnt;
                    ram_wdata <= s_data;
                    ram_we_a  <= state == LOAD_A;
                    ram_we_b  <= state == LOAD_B;
                    cnt       <= cnt == LAST ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= state == LOAD_A ? LOAD_B : FETCH;
                end
                // the extra tail cycle (rd_v set, cnt back at 0) lets the last load strobe issue
                FETCH: if (rd_v && cnt == '0) state <= WAIT;
                else begin
                    ram_addr <= cnt;
                    rd_v     <= 1'b1;
                    cnt      <= cnt == LAST ? '0 : cnt + 1'b1;
                end
                WAIT: if (cnt == WLAST) begin
                    cnt     <= '0;
                    res_sel <= '0;
                    state   <= SEL;
                end else cnt <= cnt + 1'b1;
                SEL: state <= CAP;
                CAP: begin
                    m_data  <= res_data;
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    if (cnt == LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        res_sel <= cnt + 1'b1;
                        state   <= SEL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAT_MUL_SEQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) perf_cycles <= '0;
        else if (state == IDLE && start) perf_cycles <= '0;
        else if (busy && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mat_mul_seq_ctrl.sv
// tb_mat_mul_seq_ctrl: directed bench with a behavioural RAM/datapath model around the sequencer.
module tb_mat_mul_seq_ctrl;
    localparam int DW = 16, AW = 4, NE = 9, CL = 2;

    logic          clk = 0, reset = 1, start = 0, s_valid = 0, m_ready = 1;
    logic [DW-1:0] s_data = '0;
    logic [2*DW-1:0] res_data = '0;
    logic          busy, s_ready, ram_we_a, ram_we_b, op_ld_en, m_valid, done;
    logic [AW-1:0] ram_addr, op_ld_idx, res_sel;
    logic [DW-1:0] ram_wdata;
    logic [2*DW-1:0] m_data;
`ifdef MAT_MUL_SEQ_CTRL_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 clk = ~clk;

    mat_mul_seq_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .N_ELEM(NE), .COMPUTE_LAT(CL)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .op_ld_en(op_ld_en), .op_ld_idx(op_ld_idx), .res_sel(res_sel), .res_data(res_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .done(done)
`ifdef MAT_MUL_SEQ_CTRL_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    // datapath model: two sync-read RAMs, operand registers, registered product select
    logic [DW-1:0] mem_a[16], mem_b[16], opa[9], opb[9], qa, qb;

    function automatic logic [31:0] prod(input logic [AW-1:0] sel);
        logic [31:0] acc = 0;
        int i = int'(sel) / 3;
        int j = int'(sel) % 3;
        if (sel > 8) return 0;
        for (int k = 0; k < 3; k++) acc += 32'(opa[i*3+k]) * 32'(opb[k*3+j]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr] <= ram_wdata;
        if (ram_we_b) mem_b[ram_addr] <= ram_wdata;
        qa <= mem_a[ram_addr];
        qb <= mem_b[ram_addr];
        if (op_ld_en && op_ld_idx < 9) begin
            opa[op_ld_idx] <= qa;
            opb[op_ld_idx] <= qb;
        end
        res_data <= prod(res_sel);
    end

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    logic [DW-1:0]   src[18];
    logic [31:0]     exp_r[9];
    logic [31:0]     res_q[$];
    logic [AW-1:0]   wa[$], wb[$], ld[$];
    logic [AW-1:0]   prev_addr = '0;
    int cyc = 0, ld_first = 0, ld_last = 0, first_mv = 0, n_done = 0, busy_cyc = 0;
    bit mv_seen = 0;

    always @(negedge clk) begin
        cyc++;
        if (ram_we_a) wa.push_back(ram_addr);
        if (ram_we_b) wb.push_back(ram_addr);
        if (op_ld_en) begin
            check("ld_after_addr", op_ld_idx, prev_addr);
            ld.push_back(op_ld_idx);
            if (ld.size() == 1) ld_first = cyc;
            ld_last = cyc;
        end
        prev_addr = ram_addr;
        if (m_valid && !mv_seen) begin
            mv_seen  = 1;
            first_mv = cyc;
        end
        if (done) n_done++;
        if (busy) busy_cyc++;
    end

    task automatic feed(input bit tog, input bit pulse);
        int i = 0, n = 0;
        bit took;
        s_data  = src[0];
        s_valid = 1;
        while (i < 18 && n < 1000) begin
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk);
            #1;
            n++;
            if (took) i++;
            s_data  = src[i < 18 ? i : 17];
            s_valid = i < 18 && (!tog || n % 2 == 0);
            if (pulse) start = (i == 12);
        end
        s_valid = 0;
        if (pulse) start = 0;
        if (i < 18) check("feed_timeout", i, 18);
    endtask

    task automatic drain(input int stall_at, input int nres, input bit pulse);
        int got = 0, n = 0;
        logic [31:0] held;
        m_ready = 1;
        while (got < nres && n < 3000) begin
            @(negedge clk);
            n++;
            if (pulse && got >= 3) start = (got == 4);
            if (m_valid && m_ready && got == stall_at) begin
                held    = m_data;
                m_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", m_valid, 1);
                    check("stall_data", m_data, held);
                end
                m_ready = 1;
            end
            if (m_valid && m_ready) begin
                res_q.push_back(m_data);
                got++;
            end
        end
        if (pulse) start = 0;
        if (got < nres) check("drain_timeout", got, nres);
    endtask

    task automatic run(input bit tog, input int stall_at, input int nres, input bit pulse);
        wa.delete(); wb.delete(); ld.delete(); res_q.delete();
        n_done = 0; busy_cyc = 0; mv_seen = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        fork
            feed(tog, pulse);
            drain(stall_at, nres, pulse);
        join
    endtask

    task automatic post_job();
        repeat (3) @(negedge clk);
        check("n_res", res_q.size(), 9);
        for (int i = 0; i < 9; i++) check("res", res_q[i], exp_r[i]);
        check("done_cnt", n_done, 1);
        check("busy_end", busy, 0);
        check("wa_n", wa.size(), 9);
        check("wb_n", wb.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check("wa_addr", wa[i], i);
            check("wb_addr", wb[i], i);
            check("ld_idx", ld[i], i);
        end
        check("ld_n", ld.size(), 9);
        check("ld_span", ld_last - ld_first, 8);
        check("sel_lat", first_mv - ld_last, CL + 2);
`ifdef MAT_MUL_SEQ_CTRL_PERF_EN
        check("perf", perf_cycles, busy_cyc);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_done", done, 0);
        check("rst_we", {ram_we_a, ram_we_b, op_ld_en}, 0);
        check("rst_addr", {ram_addr, op_ld_idx, res_sel}, 0);
        check("rst_m_data", m_data, 0);
        @(posedge clk); #1 reset = 0;

        src   = '{1,0,0,0,1,0,0,0,1, 1,2,3,4,5,6,7,8,9};
        exp_r = '{1,2,3,4,5,6,7,8,9};
        run(0, -1, 9, 0);
        post_job();

        src   = '{2,2,2,2,2,2,2,2,2, 3,3,3,3,3,3,3,3,3};
        exp_r = '{18,18,18,18,18,18,18,18,18};
        run(1, -1, 9, 0);
        post_job();

        src   = '{2,0,0,0,2,0,0,0,2, 1,2,3,4,5,6,7,8,9};
        exp_r = '{2,4,6,8,10,12,14,16,18};
        run(0, 4, 9, 0);
        post_job();

        src   = '{1,1,1,1,1,1,1,1,1, 1,2,3,4,5,6,7,8,9};
        exp_r = '{12,15,18,12,15,18,12,15,18};
        run(0, -1, 9, 1);
        post_job();

        src   = '{1,2,3,4,5,6,7,8,9, 1,0,0,0,1,0,0,0,1};
        run(0, -1, 3, 0);
        check("pre_rst_res0", res_q[0], 1);
        check("pre_rst_res2", res_q[2], 3);
        m_ready = 0;
        for (int n = 0; n < 10 && !m_valid; n++) @(negedge clk);
        check("pre_rst_valid", m_valid, 1);
        reset = 1;
        @(negedge clk);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", s_ready, 0);
        reset   = 0;
        m_ready = 1;
        repeat (3) @(negedge clk);
        check("idle_m_valid", m_valid, 0);
        check("idle_busy", busy, 0);

        src   = '{1,2,3,4,5,6,7,8,9, 1,2,3,4,5,6,7,8,9};
        exp_r = '{30,36,42,66,81,96,102,126,150};
        run(0, -1, 9, 0);
        post_job();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/mat_mul_seq_ctrl.md
Name: mat_mul_seq_ctrl

Overview:
Sequencer for the 3x3 fully-parallel matrix-multiply datapath. It runs four phases in order:
- accepts operand streams for A then B over a valid/ready handshake and writes them into the two operand RAMs;
- sweeps the RAMs to load the nine A/B operand registers;
- waits out the combinational compute settle time;
- drains the nine 2*DWIDTH results over a valid/ready output stream, driving the result select.

It sits between the host stream interface and the datapath, replacing the datapath's raw start/addr/we/out_sel pins.

Parameters:
DWIDTH, 16, operand width
AWIDTH, 4, RAM address width
N_ELEM, 9, elements per matrix (RAM addresses 0..N_ELEM-1)
COMPUTE_LAT, 2, cycles waited after the last operand load before draining (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a job when idle
busy  out  1  high from accepted start until the last result handshake
s_valid  in  1  input element valid
s_ready  out  1  input element accepted when s_valid&s_ready
s_data  in  DWIDTH  element, row-major; first N_ELEM are A, next N_ELEM are B
ram_addr  out  AWIDTH  shared address to both operand RAMs
ram_wdata  out  DWIDTH  write data to both RAMs
ram_we_a  out  1  write enable, RAM A
ram_we_b  out  1  write enable, RAM B
op_ld_en  out  1  load strobe for operand registers (RAM q valid this cycle)
op_ld_idx  out  AWIDTH  operand register index to load
res_sel  out  AWIDTH  result select to datapath
res_data  in  2*DWIDTH  datapath result, registered: valid 1 cycle after res_sel
m_valid  out  1  result valid
m_ready  in  1  downstream ready
m_data  out  2*DWIDTH  result, C0..C8 in order
done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset (synchronous, active-high; clock clk) takes priority in any state.
  - State goes to IDLE; all counters go to 0.
  - busy, s_ready, ram_we_a, ram_we_b, op_ld_en, m_valid and done go to 0.
  - ram_addr, op_ld_idx and res_sel go to 0; m_data goes to 0.
  - Reset mid-job abandons the job; partial RAM contents are don't-care.
- IDLE:
  - s_ready=0.
  - start=1 moves to LOAD_A and sets busy=1 from the next cycle.
  - start while busy is ignored.
- LOAD_A:
  - s_ready=1.
  - Each handshake registers ram_addr=cnt, ram_wdata=s_data and ram_we_a=1 for exactly one cycle; cnt increments.
  - A cycle with no handshake produces no write.
  - After handshake N_ELEM-1: cnt=0, go to LOAD_B.
- LOAD_B: identical to LOAD_A but drives ram_we_b; after the last handshake, go to FETCH.
- FETCH:
  - s_ready=0.
  - Drives ram_addr=k for k=0..N_ELEM-1 on consecutive cycles.
  - One cycle after address k, drives op_ld_en=1 and op_ld_idx=k (1-cycle RAM read latency).
  - Duration is N_ELEM+1 cycles, then go to WAIT.
- WAIT: counts COMPUTE_LAT cycles, then go to SEL with r=0.
- SEL:
  - Drives res_sel=r for one cycle.
  - The next cycle captures res_data into m_data, sets m_valid=1 and goes to OUT.
- OUT:
  - m_data and m_valid are held stable until m_ready.
  - On handshake: m_valid=0.
  - If r<N_ELEM-1: r++, go to SEL.
  - Otherwise: done=1 for one cycle, busy=0, go to IDLE.
- Result throughput is at most one per 3 cycles; this is acceptable.
- Counters are AWIDTH wide and never exceed N_ELEM-1; no wrap-around occurs.
- res_sel holds its last value outside SEL.
- m_valid is never deasserted without a handshake, except on reset.
- s_ready is 0 in every state except LOAD_A/LOAD_B, so s_valid outside those states is not consumed.

Optional Feature:
Macro: MAT_MUL_SEQ_CTRL_PERF_EN.
- Defined: adds output perf_cycles [31:0].
  - Cleared on the accepted start.
  - Increments every cycle while busy; holds its value after done until the next start.
  - Saturates at 32'hFFFFFFFF; reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start. Stream A=identity (1,0,0,0,1,0,0,0,1) and B=1..9 with s_valid always high and m_ready always high. Required: m_data = 1,2,...,9 in order, done pulses once, busy=0 afterwards.
- Stream A=all 2 and B=all 3 with s_valid toggling every other cycle. Required: exactly 18 writes (9 ram_we_a, then 9 ram_we_b) at addresses 0..8, and every result = 18.
- Hold m_ready=0 for 5 cycles when result 4 appears. Required: m_valid and m_data stay stable for those cycles, and there is no drop or duplicate: 9 results total.
- Pulse start again during LOAD_B and during OUT. Required: ignored; the job completes normally with a single done.
- Assert reset during the drain after 3 results. Required: next cycle m_valid=0, busy=0, state IDLE. A fresh job then produces correct results.
- Check FETCH timing. Required: op_ld_en high for exactly 9 consecutive cycles, op_ld_idx 0..8, each one cycle after the matching ram_addr. First SEL occurs COMPUTE_LAT cycles after the last op_ld_en. With the PERF macro defined, perf_cycles matches the cycle count measured by the bench.
